// File: rtl/isa_vga_target_if.sv
// ISA bus and backend memory port bundle for isa_vga_target.
// The slave modport is the target's view. The master modport is the
// bridge and memory model's view.
interface isa_vga_target_if;
  // ISA bridge side
  logic        BALE;
  logic        SA0;
  logic        SA12;
  logic        MEMR;
  logic        MEMW;
  logic        IOR;
  logic        IOW;
  logic [15:0] DG_in;
  logic [15:0] DG_out;
  logic        DG_oe;
  logic        WAIT;
  // backend memory side
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  BALE, SA0, SA12, MEMR, MEMW, IOR, IOW, DG_in, mem_rdata, mem_ack,
    output DG_out, DG_oe, WAIT, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output BALE, SA0, SA12, MEMR, MEMW, IOR, IOW, DG_in, mem_rdata, mem_ack,
    input  DG_out, DG_oe, WAIT, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/isa_vga_target.sv
// ISA bus target for the VGA/Amiga monitor switch card.
// Memory cycles are forwarded to a backend and hold WAIT low until the
// backend acknowledges or a timeout expires. IO cycles complete with no
// wait states. They expose the monitor switch, an ID word and a sticky
// error flag.
module isa_vga_target #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [15:0] IO_ID   = 16'h5A01
) (
  input  logic              mclk,
  input  logic              reset,
  isa_vga_target_if.slave   bus,
  output logic              monisw,
  output logic              err
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    MEMACC,
    IOACC,
    DONE,
    ENDWAIT
  } state_t;

  state_t         state_q, state_d;
  logic [6:0]     sync1_q, sync2_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     addr_q, addr_d;
  logic           we_q, we_d;
  logic           rd_q, rd_d;
  logic [15:0]    wdata_q, wdata_d;
  logic [15:0]    dg_out_q, dg_out_d;
  logic           monisw_q, monisw_d;
  logic           err_q, err_d;

  // synchronized bus inputs (active-low strobes and BALE)
  logic bale_s, sa0_s, sa12_s, memr_s, memw_s, ior_s, iow_s;
  logic memr_a, memw_a, ior_a, iow_a;
  logic [2:0] n_act;
  logic       all_idle;

  assign {bale_s, sa0_s, sa12_s, memr_s, memw_s, ior_s, iow_s} = sync2_q;
  assign memr_a   = ~memr_s;
  assign memw_a   = ~memw_s;
  assign ior_a    = ~ior_s;
  assign iow_a    = ~iow_s;
  assign n_act    = {2'b00, memr_a} + {2'b00, memw_a} + {2'b00, ior_a} + {2'b00, iow_a};
  assign all_idle = memr_s & memw_s & ior_s & iow_s;

  // two-flop synchronizer on every bus control/address input, idles high
  always_ff @(posedge mclk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {bus.BALE, bus.SA0, bus.SA12, bus.MEMR, bus.MEMW, bus.IOR, bus.IOW};
      sync2_q <= sync1_q;
    end
  end

  // state and datapath registers
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      rd_q     <= 1'b0;
      wdata_q  <= '0;
      dg_out_q <= '0;
      monisw_q <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
      dg_out_q <= dg_out_d;
      monisw_q <= monisw_d;
      err_q    <= err_d;
    end
  end

  // next-state and datapath update for the bus cycle sequencer
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    rd_d     = rd_q;
    wdata_d  = wdata_q;
    dg_out_d = dg_out_q;
    monisw_d = monisw_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (!bale_s) begin
          addr_d  = {sa12_s, sa0_s};
          state_d = ADDR;
        end else if (!all_idle) begin
          err_d   = 1'b1;
          state_d = ENDWAIT;
        end
      end

      ADDR: begin
        if (n_act > 3'd1) begin
          err_d   = 1'b1;
          state_d = ENDWAIT;
        end else if (memr_a || memw_a) begin
          cnt_d   = '0;
          we_d    = memw_a;
          rd_d    = memr_a;
          wdata_d = bus.DG_in;
          state_d = MEMACC;
        end else if (ior_a || iow_a) begin
          rd_d    = ior_a;
          state_d = IOACC;
        end
      end

      MEMACC: begin
        // an ack that lands on the final counted cycle still wins over the timeout
        if (bus.mem_ack) begin
          if (rd_q) dg_out_d = bus.mem_rdata;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          dg_out_d = 16'hFFFF;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      IOACC: begin
        if (rd_q) begin
          dg_out_d = addr_q[0] ? IO_ID : {15'b0, monisw_q};
        end else if (addr_q[0]) begin
          err_d = 1'b0;
        end else begin
          monisw_d = bus.DG_in[0];
        end
        state_d = DONE;
      end

      DONE: begin
        if (all_idle) state_d = ENDWAIT;
      end

      ENDWAIT: begin
        if (bale_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Bus handshake outputs decode the state directly and are gated by reset.
  // This lets an access abort in the cycle where reset rises.
  // DG_oe drops as soon as the strobes are released. If the strobes were
  // released during MEMACC, DG_oe therefore never rises.
  assign bus.WAIT      = reset | (state_q != MEMACC);
  assign bus.mem_req   = ~reset & (state_q == MEMACC);
  assign bus.DG_oe     = ~reset & (state_q == DONE) & rd_q & ~all_idle;
  assign bus.DG_out    = dg_out_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign monisw        = monisw_q;
  assign err           = err_q;

endmodule

// File: tb/tb_isa_vga_target.sv
// Directed bench for isa_vga_target: memory read/write with backend,
// timeout, ack on the limit cycle, IO register access, strobe errors and
// reset during an access.
module tb_isa_vga_target;

  logic mclk = 1'b0;
  logic reset;
  logic monisw;
  logic err;
  int   checks = 0;
  int   errors = 0;

  isa_vga_target_if bus ();

  isa_vga_target #(.TIMEOUT(64), .IO_ID(16'h5A01)) dut (
    .mclk   (mclk),
    .reset  (reset),
    .bus    (bus),
    .monisw (monisw),
    .err    (err)
  );

  always #10 mclk = ~mclk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic a12, input logic a0);
    bus.SA12 = a12;
    bus.SA0  = a0;
    bus.BALE = 1'b0;
    tick(4);
  endtask

  task automatic finish_cycle();
    bus.MEMR = 1'b1;
    bus.MEMW = 1'b1;
    bus.IOR  = 1'b1;
    bus.IOW  = 1'b1;
    tick(4);
    bus.BALE = 1'b1;
    tick(4);
  endtask

  task automatic wait_req(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (bus.mem_req === 1'b1) seen = 1'b1;
      else tick(1);
    end
  endtask

  task automatic io_write(input logic a0, input logic [15:0] data);
    start(1'b0, a0);
    bus.DG_in = data;
    bus.IOW   = 1'b0;
    tick(6);
    finish_cycle();
  endtask

  initial begin
    logic seen;
    logic flag_a;
    logic flag_b;
    int   n;

    reset         = 1'b1;
    bus.BALE      = 1'b1;
    bus.SA0       = 1'b0;
    bus.SA12      = 1'b0;
    bus.MEMR      = 1'b1;
    bus.MEMW      = 1'b1;
    bus.IOR       = 1'b1;
    bus.IOW       = 1'b1;
    bus.DG_in     = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    tick(3);

    chk("rst_wait",   bus.WAIT, 1);
    chk("rst_oe",     bus.DG_oe, 0);
    chk("rst_dgout",  bus.DG_out, 16'h0000);
    chk("rst_req",    bus.mem_req, 0);
    chk("rst_we",     bus.mem_we, 0);
    chk("rst_addr",   bus.mem_addr, 0);
    chk("rst_wdata",  bus.mem_wdata, 0);
    chk("rst_monisw", monisw, 1);
    chk("rst_err",    err, 0);
    reset = 1'b0;
    tick(2);

    // memory read, ack three cycles after the request
    start(1'b1, 1'b0);
    bus.MEMR = 1'b0;
    wait_req(seen);
    chk("rd_req_seen", seen, 1);
    chk("rd_wait_low", bus.WAIT, 0);
    chk("rd_addr", bus.mem_addr, 2'b10);
    chk("rd_we", bus.mem_we, 0);
    tick(3);
    chk("rd_req_held", bus.mem_req, 1);
    chk("rd_wait_ack_cycle", bus.WAIT, 0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    tick(1);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    chk("rd_wait_released", bus.WAIT, 1);
    chk("rd_req_dropped", bus.mem_req, 0);
    chk("rd_data", bus.DG_out, 16'hBEEF);
    chk("rd_oe", bus.DG_oe, 1);
    tick(3);
    chk("rd_oe_held", bus.DG_oe, 1);
    bus.MEMR = 1'b1;
    tick(3);
    chk("rd_oe_off", bus.DG_oe, 0);
    chk("rd_err", err, 0);
    bus.BALE = 1'b1;
    tick(4);

    // memory write with no ack: timeout
    start(1'b0, 1'b0);
    bus.DG_in = 16'h1234;
    bus.MEMW  = 1'b0;
    wait_req(seen);
    chk("wr_req_seen", seen, 1);
    chk("wr_we", bus.mem_we, 1);
    chk("wr_wdata", bus.mem_wdata, 16'h1234);
    n = 0;
    for (int i = 0; i < 200 && bus.WAIT === 1'b0; i++) begin
      n++;
      tick(1);
    end
    chk("wr_wait_cycles", n, 64);
    chk("wr_err", err, 1);
    chk("wr_req_off", bus.mem_req, 0);
    chk("wr_dgout_ff", bus.DG_out, 16'hFFFF);
    chk("wr_oe", bus.DG_oe, 0);
    finish_cycle();
    io_write(1'b1, 16'hFFFF);
    chk("err_clear1", err, 0);

    // IO write to the monitor switch, no wait states
    start(1'b0, 1'b0);
    bus.DG_in = 16'h0000;
    bus.IOW   = 1'b0;
    flag_a    = 1'b0;
    repeat (6) begin
      tick(1);
      if (bus.WAIT !== 1'b1) flag_a = 1'b1;
    end
    chk("io_wait_never_low", flag_a, 0);
    chk("io_monisw", monisw, 0);
    finish_cycle();

    // IO read of the switch register
    start(1'b0, 1'b0);
    bus.IOR = 1'b0;
    tick(6);
    chk("io_rd_sw", bus.DG_out, 16'h0000);
    chk("io_rd_sw_oe", bus.DG_oe, 1);
    finish_cycle();

    // IO read of the ID register
    start(1'b0, 1'b1);
    bus.IOR = 1'b0;
    tick(6);
    chk("io_rd_id", bus.DG_out, 16'h5A01);
    chk("io_rd_id_oe", bus.DG_oe, 1);
    bus.IOR = 1'b1;
    tick(3);
    chk("io_rd_oe_off", bus.DG_oe, 0);
    bus.BALE = 1'b1;
    tick(4);

    // two strobes at once
    start(1'b0, 1'b0);
    bus.MEMR = 1'b0;
    bus.IOR  = 1'b0;
    flag_a   = 1'b0;
    flag_b   = 1'b0;
    repeat (8) begin
      tick(1);
      if (bus.mem_req !== 1'b0) flag_a = 1'b1;
      if (bus.DG_oe !== 1'b0) flag_b = 1'b1;
    end
    chk("dbl_err", err, 1);
    chk("dbl_no_req", flag_a, 0);
    chk("dbl_no_oe", flag_b, 0);
    finish_cycle();
    io_write(1'b1, 16'h0000);
    chk("err_clear2", err, 0);

    // strobe while idle without BALE
    bus.IOR = 1'b0;
    tick(5);
    chk("idle_strobe_err", err, 1);
    chk("idle_strobe_oe", bus.DG_oe, 0);
    bus.IOR = 1'b1;
    tick(4);
    io_write(1'b1, 16'h0000);
    chk("err_clear3", err, 0);

    // ack on the last counted cycle counts as success
    start(1'b0, 1'b0);
    bus.MEMR = 1'b0;
    wait_req(seen);
    chk("lim_req_seen", seen, 1);
    tick(63);
    chk("lim_wait_low", bus.WAIT, 0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h0A5A;
    tick(1);
    bus.mem_ack   = 1'b0;
    chk("lim_wait_released", bus.WAIT, 1);
    chk("lim_err", err, 0);
    chk("lim_data", bus.DG_out, 16'h0A5A);
    chk("lim_req_off", bus.mem_req, 0);
    finish_cycle();

    // reset in the middle of a memory access
    start(1'b1, 1'b1);
    bus.MEMR = 1'b0;
    wait_req(seen);
    chk("rst_mid_req_seen", seen, 1);
    tick(2);
    reset = 1'b1;
    #1;
    chk("rst_mid_wait_now", bus.WAIT, 1);
    chk("rst_mid_req_now", bus.mem_req, 0);
    tick(1);
    chk("rst_mid_wait", bus.WAIT, 1);
    chk("rst_mid_req", bus.mem_req, 0);
    chk("rst_mid_monisw", monisw, 1);
    chk("rst_mid_addr", bus.mem_addr, 0);
    bus.MEMR = 1'b1;
    bus.BALE = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    chk("post_rst_req", bus.mem_req, 0);
    start(1'b0, 1'b0);
    bus.IOR = 1'b0;
    tick(6);
    chk("post_rst_io_rd", bus.DG_out, 16'h0001);
    finish_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/isa_vga_target.md
ISA_VGA_TARGET -- requirements
Module: isa_vga_target

Interface
REQ-001 Parameter TIMEOUT, 64, maximum mclk cycles WAIT is held low per memory access.
REQ-002 Parameter IO_ID, 16'h5A01, read-only identification value.
REQ-003 mclk  in  1  single clock, 50 MHz; every flop on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 BALE  in  1  active-low address latch enable from the bridge.
REQ-006 SA0, SA12  in  1 each  bridge address lines.
REQ-007 MEMR, MEMW, IOR, IOW  in  1 each  active-low bus strobes.
REQ-008 DG_in  in  16  write data from bus.
REQ-009 DG_out  out  16  read data to bus.
REQ-010 DG_oe  out  1  1 = drive DG_out onto the bus.
REQ-011 WAIT  out  1  bus ready; 0 = not ready.
REQ-012 mem_req, mem_we  out  1 each  backend memory request and direction (1 = write).
REQ-013 mem_addr  out  2  latched {SA12,SA0}.
REQ-014 mem_wdata  out  16  backend write data.
REQ-015 mem_rdata  in  16  backend read data.
REQ-016 mem_ack  in  1  single-cycle backend completion.
REQ-017 monisw  out  1  monitor switch: 1 = Amiga, 0 = VGA.
REQ-018 err  out  1  sticky error flag.

Function
REQ-019 All bus inputs (BALE, SA0, SA12, strobes) SHALL pass a 2-flop synchronizer; all decisions below use synchronized values.
REQ-020 Address {SA12,SA0} SHALL be latched on the first cycle synchronized BALE is 0 while in IDLE.
REQ-021 FSM states: IDLE, ADDR, MEMACC, IOACC, DONE, ENDWAIT.
REQ-022 IDLE->ADDR on synchronized BALE=0; ADDR waits for exactly one active strobe.
REQ-023 ADDR->MEMACC on MEMR or MEMW low: WAIT=0 in the same cycle; mem_req=1; mem_we=~MEMW; DG_in captured into mem_wdata on entry.
REQ-024 MEMACC holds mem_req=1 until mem_ack=1, then enters DONE; on a read, mem_rdata is latched into DG_out.
REQ-025 Timeout counter SHALL start at 0 on MEMACC entry; on reaching TIMEOUT-1 without ack: mem_req=0, DG_out=16'hFFFF, err=1, go to DONE.
REQ-026 mem_ack in the same cycle as the timeout limit SHALL count as success; err unchanged.
REQ-027 ADDR->IOACC on IOR or IOW low: no wait states; WAIT stays 1.
REQ-028 IO read, address bit SA0=0: returns {15'b0, monisw}.
REQ-029 IO read, address bit SA0=1: returns IO_ID.
REQ-030 IO write, SA0=0: monisw <= DG_in[0].
REQ-031 IO write, SA0=1: clears err; all other bits ignored.
REQ-032 IOACC->DONE after 1 cycle.
REQ-033 DONE: WAIT=1; DG_oe=1 for read cycles only; hold until all four synchronized strobes are 1, then go to ENDWAIT.
REQ-034 ENDWAIT: DG_oe=0; return to IDLE when synchronized BALE=1.
REQ-035 If more than one strobe is active in ADDR, or a strobe is active in IDLE without BALE: err=1, no access, go to ENDWAIT.
REQ-036 Strobes released during MEMACC: the access completes internally; DG_oe stays 0; then proceed as DONE.
REQ-037 WAIT SHALL never be 0 outside MEMACC.
REQ-038 mem_req SHALL never be 1 outside MEMACC.

Reset
REQ-039 While reset=1, all outputs SHALL hold: state IDLE, WAIT=1, DG_oe=0, DG_out=16'h0000, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, monisw=1, err=0, counter=0, synchronizers=1.
REQ-040 Reset asserted mid-access SHALL abort within the same cycle with no further mem_req.

Verification
REQ-041 BALE low, SA12=1 SA0=0, MEMR low; mem_ack 3 cycles after mem_req, rdata=16'hBEEF -> mem_addr=2'b10, WAIT low until ack+1, DG_out=16'hBEEF with DG_oe=1 until MEMR high.
REQ-042 MEMW low, DG_in=16'h1234, no ack -> mem_we=1, mem_wdata=16'h1234, WAIT released after 64 cycles, err=1.
REQ-043 IOW low, SA0=0, DG_in=16'h0000 -> monisw=0, WAIT never low; then IOR low, SA0=1 -> DG_out=16'h5A01.
REQ-044 MEMR and IOR low together after BALE -> err=1, mem_req stays 0, DG_oe stays 0.
REQ-045 reset pulsed during MEMACC -> next cycle WAIT=1, mem_req=0, monisw=1, state IDLE.
REQ-046 mem_ack on exactly cycle TIMEOUT-1 -> normal completion, err stays 0.
